// File: rtl/compare_sort_pkg.sv
// -----------------------------------------------------------------------------
// compare_sort_pkg
// Shared definitions for the compare_sort_ctrl batch sort engine:
//   - state_e     : engine phases (load batch, bubble-sort it, stream it out)
//   - DEPTH_MAX   : largest supported batch size
//   - cnt_width() : width of a counter able to hold the values 0..depth
// -----------------------------------------------------------------------------
package compare_sort_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int DEPTH_MAX = 16;

    // Width needed to count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/compare_sort_ctrl_cmp_unit.sv
// -----------------------------------------------------------------------------
// cmp_unit
// Combinational unsigned magnitude comparator shared by the sort engine.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   gt   : a > b
//   eq   : a == b
// -----------------------------------------------------------------------------
module cmp_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/compare_sort_ctrl.sv
// -----------------------------------------------------------------------------
// compare_sort_ctrl
// Batch sort engine: collects up to DEPTH unsigned words, bubble-sorts them in
// place with one shared comparator (one compare per cycle), then streams them
// out in ascending order.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last    : input word stream
//   out_valid/out_ready/out_data/out_last : sorted output stream
//   busy                          : high while the sort passes are running
// Build option:
//   COMPARE_SORT_EARLY_EXIT_EN    : when defined, a pass with no swaps ends the
//                                   sort early; otherwise all passes always run.
// -----------------------------------------------------------------------------
module compare_sort_ctrl
    import compare_sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = cnt_width(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    n_q, n_d;
    logic [IW-1:0]    p_q, p_d;
    logic [IW-1:0]    j_q, j_d;
    logic [IW-1:0]    k_q, k_d;
    logic             in_ready_q, in_ready_d;

    logic [IW-1:0]    j_nx_s;
    logic [WIDTH-1:0] cmp_a_s, cmp_b_s;
    logic             gt_s, eq_s, swap_s;
    logic             in_fire_s, out_fire_s;
    logic [CW-1:0]    n_inc_s, n_last_s, j_end_s;
    logic             load_close_s, pass_end_s, last_pass_s, sort_exit_s;

`ifdef COMPARE_SORT_EARLY_EXIT_EN
    logic             swapped_q, swapped_d;
    logic             early_done_s;
`endif

    // Comparator operand muxes: the adjacent pair selected by j.
    assign j_nx_s  = j_q + IW'(1);
    assign cmp_a_s = mem_q[j_q];
    assign cmp_b_s = mem_q[j_nx_s];

    cmp_unit #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (cmp_a_s),
        .b  (cmp_b_s),
        .gt (gt_s),
        .eq (eq_s)
    );

    // Equal words never move, which keeps the sort stable.
    assign swap_s = gt_s & ~eq_s;

    assign in_fire_s  = (state_q == ST_LOAD) && in_valid && in_ready_q;
    assign out_fire_s = (state_q == ST_OUT) && out_ready;

    assign n_inc_s      = n_q + CW'(1);
    assign n_last_s     = n_q - CW'(1);
    assign load_close_s = in_last || (n_inc_s == CW'(DEPTH));

    // Last compare index of pass p is N-2-p; the final pass is p == N-2.
    assign j_end_s     = n_q - CW'(2) - CW'(p_q);
    assign pass_end_s  = (CW'(j_q) == j_end_s);
    assign last_pass_s = ((CW'(p_q) + CW'(1)) == n_last_s);

`ifdef COMPARE_SORT_EARLY_EXIT_EN
    assign early_done_s = ~(swapped_q | swap_s);
    assign sort_exit_s  = pass_end_s && (last_pass_s || early_done_s);
`else
    assign sort_exit_s  = pass_end_s && last_pass_s;
`endif

    // Next-state and counter logic for the LOAD/SORT/OUT sequence.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        p_d     = p_q;
        j_d     = j_q;
        k_d     = k_q;
`ifdef COMPARE_SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_fire_s) begin
                    n_d = n_inc_s;
                    if (load_close_s) begin
                        p_d = '0;
                        j_d = '0;
                        k_d = '0;
`ifdef COMPARE_SORT_EARLY_EXIT_EN
                        swapped_d = 1'b0;
`endif
                        // A one-word batch is already sorted.
                        if (n_inc_s == CW'(1)) begin
                            state_d = ST_OUT;
                        end else begin
                            state_d = ST_SORT;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SORT: begin
                if (sort_exit_s) begin
                    state_d = ST_OUT;
                    k_d     = '0;
                    j_d     = '0;
                end else if (pass_end_s) begin
                    p_d = p_q + IW'(1);
                    j_d = '0;
`ifdef COMPARE_SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                end else begin
                    j_d = j_nx_s;
`ifdef COMPARE_SORT_EARLY_EXIT_EN
                    swapped_d = swapped_q | swap_s;
`endif
                end
            end
            ST_OUT: begin
                if (out_fire_s) begin
                    if (CW'(k_q) == n_last_s) begin
                        state_d = ST_LOAD;
                        n_d     = '0;
                        k_d     = '0;
                        p_d     = '0;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_LOAD;
                n_d     = '0;
                p_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
        endcase
        // Ready is registered so it is a clean function of the next state.
        in_ready_d = (state_d == ST_LOAD);
    end

    // Storage update: load writes one slot, sort swaps the compared pair.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (in_fire_s) begin
            mem_d[n_q[IW-1:0]] = in_data;
        end else if ((state_q == ST_SORT) && swap_s) begin
            mem_d[j_q]    = mem_q[j_nx_s];
            mem_d[j_nx_s] = mem_q[j_q];
        end else begin
            mem_d[0] = mem_q[0];
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            n_q        <= '0;
            p_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            p_q        <= p_d;
            j_q        <= j_d;
            k_q        <= k_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef COMPARE_SORT_EARLY_EXIT_EN
    // Per-pass record of whether any swap happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swapped_q <= 1'b0;
        end else begin
            swapped_q <= swapped_d;
        end
    end
`endif

    // Word storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs decode registered state only; data is forced to zero when idle.
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_valid ? mem_q[k_q] : '0;
    assign out_last  = out_valid && (CW'(k_q) == n_last_s);
    assign busy      = (state_q == ST_SORT);

endmodule

// File: tb/tb_compare_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_compare_sort_ctrl
// Directed self-checking bench for compare_sort_ctrl (WIDTH=8, DEPTH=8).
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, i.e. well away from the active edge.
// -----------------------------------------------------------------------------
module tb_compare_sort_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_checks;
    int n_fails;

    logic [7:0] in_vec  [16];
    logic [7:0] exp_vec [16];

    compare_sort_ctrl #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present cnt words from in_vec; in_last on the final one if requested.
    task automatic load_words(input int cnt, input bit last_on_final);
        for (int i = 0; i < cnt; i++) begin
            int w;
            in_valid = 1'b1;
            in_data  = in_vec[i];
            in_last  = last_on_final && (i == cnt - 1);
            w = 0;
            while (!in_ready && w < 100) begin
                step();
                w++;
            end
            check_eq("load_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
    endtask

    // Count cycles with busy high, starting at the cycle after the close beat.
    task automatic expect_sort(input int exp_cycles);
        int c;
        check_eq("in_ready_low", {31'd0, in_ready}, 32'd0);
        c = 0;
        while (busy && c < 200) begin
            c++;
            step();
        end
        check_eq("sort_cycles", c, exp_cycles);
    endtask

    // Read cnt words with out_ready high and compare against exp_vec.
    task automatic drain(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int w;
            w = 0;
            while (!out_valid && w < 100) begin
                step();
                w++;
            end
            check_eq("out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("out_data", {24'd0, out_data}, {24'd0, exp_vec[i]});
            check_eq("out_last", {31'd0, out_last}, {31'd0, (i == cnt - 1)});
            step();
        end
        check_eq("ready_after_out", {31'd0, in_ready}, 32'd1);
        check_eq("valid_after_out", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        check_eq("rel_in_ready_lo", {31'd0, in_ready}, 32'd0);
        step();
        check_eq("rel_in_ready_hi", {31'd0, in_ready}, 32'd1);

        // Unsorted batch of 8 closed by in_last
        in_vec[0] = 8'd8; in_vec[1] = 8'd3; in_vec[2] = 8'd5; in_vec[3] = 8'd1;
        in_vec[4] = 8'd9; in_vec[5] = 8'd2; in_vec[6] = 8'd7; in_vec[7] = 8'd4;
        exp_vec[0] = 8'd1; exp_vec[1] = 8'd2; exp_vec[2] = 8'd3; exp_vec[3] = 8'd4;
        exp_vec[4] = 8'd5; exp_vec[5] = 8'd7; exp_vec[6] = 8'd8; exp_vec[7] = 8'd9;
        load_words(8, 1'b1);
`ifdef COMPARE_SORT_EARLY_EXIT_EN
        expect_sort(25);
`else
        expect_sort(28);
`endif
        drain(8);

        // Already sorted 1..8
        for (int i = 0; i < 8; i++) begin
            in_vec[i]  = 8'(i + 1);
            exp_vec[i] = 8'(i + 1);
        end
        load_words(8, 1'b1);
`ifdef COMPARE_SORT_EARLY_EXIT_EN
        expect_sort(7);
`else
        expect_sort(28);
`endif
        drain(8);

        // Single word batch skips sorting
        in_vec[0]  = 8'hAA;
        exp_vec[0] = 8'hAA;
        load_words(1, 1'b1);
        expect_sort(0);
        drain(1);

        // Nine words, no in_last: DEPTH closes the batch; 9th waits
        for (int i = 0; i < 8; i++) begin
            in_vec[i]  = 8'(8 - i);
            exp_vec[i] = 8'(i + 1);
        end
        load_words(8, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b1;
        expect_sort(28);
        drain(8);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("ninth_busy", {31'd0, busy}, 32'd0);
        check_eq("ninth_valid", {31'd0, out_valid}, 32'd1);
        check_eq("ninth_data", {24'd0, out_data}, 32'h11);
        check_eq("ninth_last", {31'd0, out_last}, 32'd1);
        step();
        check_eq("ninth_done", {31'd0, in_ready}, 32'd1);

        // Output back-pressure with duplicates and extremes
        in_vec[0] = 8'd5; in_vec[1] = 8'd5; in_vec[2] = 8'hFF; in_vec[3] = 8'd0;
        exp_vec[0] = 8'd0; exp_vec[1] = 8'd5; exp_vec[2] = 8'd5; exp_vec[3] = 8'hFF;
        out_ready = 1'b0;
        load_words(4, 1'b1);
        expect_sort(6);
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_data", {24'd0, out_data}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        drain(4);

        // Reset in the middle of a sort
        for (int i = 0; i < 8; i++) begin
            in_vec[i] = 8'(8 - i);
        end
        load_words(8, 1'b1);
        repeat (5) step();
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        check_eq("abort_rel_lo", {31'd0, in_ready}, 32'd0);
        step();
        check_eq("abort_rel_hi", {31'd0, in_ready}, 32'd1);
        in_vec[0] = 8'd3; in_vec[1] = 8'd1; in_vec[2] = 8'd2;
        exp_vec[0] = 8'd1; exp_vec[1] = 8'd2; exp_vec[2] = 8'd3;
        load_words(3, 1'b1);
        expect_sort(3);
        drain(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
